// File: rtl/jtkunio_pkg.sv
// Shared definitions for the Kunio ROM arbiter: FSM encoding and default client-1 base.
package jtkunio_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } arb_state_e;

    // Downstream base for sound CPU fetches.
    localparam logic [17:0] OFFSET1_DEF = 18'h20000;

endpackage

// File: rtl/jtkunio_rom_slot.sv
// One-entry read cache for a single client: tag, byte and valid bit.
module jtkunio_rom_slot #(
    parameter int unsigned AW = 17,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_i,
    input  logic          cs_i,
    input  logic          fill_i,
    input  logic [AW-1:0] fill_tag_i,
    input  logic [DW-1:0] fill_data_i,
    output logic          hit_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic [AW-1:0] tag_q;
    logic [DW-1:0] byte_q;

    // Capture the fetched byte and its address when the arbiter completes a fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            byte_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag_i;
            byte_q  <= fill_data_i;
        end
    end

    // A client with cs low never sees a hit.
    always_comb begin
        hit_o  = cs_i & valid_q & (tag_q == addr_i);
        data_o = byte_q;
    end

endmodule

// File: rtl/jtkunio_rom_arb.sv
// Arbitrates the main and sound CPU ROM reads onto one downstream port,
// caching the last byte fetched for each client.
module jtkunio_rom_arb
    import jtkunio_pkg::*;
#(
    parameter int unsigned     AW0     = 17,
    parameter int unsigned     AW1     = 15,
    parameter int unsigned     AWD     = 18,
    parameter logic [AWD-1:0]  OFFSET1 = AWD'(OFFSET1_DEF),
    parameter int unsigned     DW      = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [AW0-1:0] main_addr,
    input  logic           main_cs,
    output logic [DW-1:0]  main_data,
    output logic           main_ok,
    input  logic [AW1-1:0] snd_addr,
    input  logic           snd_cs,
    output logic [DW-1:0]  snd_data,
    output logic           snd_ok,
    output logic [AWD-1:0] rom_addr,
    output logic           rom_cs,
    input  logic [DW-1:0]  rom_data,
    input  logic           rom_ok
);

    arb_state_e     state_q;
    logic           gnt_q;   // client currently being fetched (0 main, 1 sound)
    logic           last_q;  // client granted most recently
    logic           rom_cs_q;
    logic [AWD-1:0] rom_addr_q;
    logic [AW0-1:0] main_pend_q;
    logic [AW1-1:0] snd_pend_q;

    logic           main_hit, snd_hit;
    logic           main_miss, snd_miss;
    logic           gnt_d;
    logic           fill_main, fill_snd;
    logic [AWD-1:0] main_rom_addr, snd_rom_addr;

    jtkunio_rom_slot #(
        .AW (AW0),
        .DW (DW)
    ) u_main_slot (
        .clk         (clk),
        .rst         (rst),
        .addr_i      (main_addr),
        .cs_i        (main_cs),
        .fill_i      (fill_main),
        .fill_tag_i  (main_pend_q),
        .fill_data_i (rom_data),
        .hit_o       (main_hit),
        .data_o      (main_data)
    );

    jtkunio_rom_slot #(
        .AW (AW1),
        .DW (DW)
    ) u_snd_slot (
        .clk         (clk),
        .rst         (rst),
        .addr_i      (snd_addr),
        .cs_i        (snd_cs),
        .fill_i      (fill_snd),
        .fill_tag_i  (snd_pend_q),
        .fill_data_i (rom_data),
        .hit_o       (snd_hit),
        .data_o      (snd_data)
    );

    // Miss detection, round-robin grant choice and downstream address mapping.
    always_comb begin
        main_miss     = main_cs & ~main_hit;
        snd_miss      = snd_cs & ~snd_hit;
        gnt_d         = (main_miss & snd_miss) ? ~last_q : snd_miss;
        main_rom_addr = AWD'(main_addr);
        // Wraps modulo 2^AWD by truncation.
        snd_rom_addr  = OFFSET1 + AWD'(snd_addr);
        fill_main     = (state_q == StWait) & rom_ok & ~gnt_q;
        fill_snd      = (state_q == StWait) & rom_ok & gnt_q;
        main_ok       = main_hit;
        snd_ok        = snd_hit;
        rom_cs        = rom_cs_q;
        rom_addr      = rom_addr_q;
    end

    // Fetch sequencer: grant in IDLE, skip one cycle of possibly stale rom_ok, fill on rom_ok.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            rom_cs_q    <= 1'b0;
            rom_addr_q  <= '0;
            main_pend_q <= '0;
            snd_pend_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (main_miss | snd_miss) begin
                        gnt_q       <= gnt_d;
                        last_q      <= gnt_d;
                        rom_addr_q  <= gnt_d ? snd_rom_addr : main_rom_addr;
                        main_pend_q <= main_addr;
                        snd_pend_q  <= snd_addr;
                        rom_cs_q    <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (rom_ok) begin
                        rom_cs_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    rom_cs_q <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule
